// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the SS.hh stopwatch sequencer.
package stopwatch_pkg;

   localparam int unsigned BCD_W               = 4;
   localparam int unsigned NUM_DIGITS          = 4;
   localparam logic [BCD_W-1:0] BCD_MAX        = 4'd9;
   localparam int unsigned TICK_DIV_DEFAULT    = 1_000_000;
   localparam int unsigned SYNC_STAGES_DEFAULT = 2;

   localparam int unsigned NUM_BTN        = 3;
   localparam int unsigned BTN_START_STOP = 0;
   localparam int unsigned BTN_CLEAR      = 1;
   localparam int unsigned BTN_LAP        = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Display payload, d3 = tens of seconds ... d0 = units of hundredths
   typedef struct packed {
      logic [BCD_W-1:0] d3;
      logic [BCD_W-1:0] d2;
      logic [BCD_W-1:0] d1;
      logic [BCD_W-1:0] d0;
   } bcd_time_t;

   function automatic logic time_is_max(input bcd_time_t t);
      return (t.d3 == BCD_MAX) && (t.d2 == BCD_MAX) &&
             (t.d1 == BCD_MAX) && (t.d0 == BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One mod-10 BCD digit with synchronous clear and ripple carry to the next digit.
module bcd_digit_counter
   import stopwatch_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [BCD_W-1:0] q,
   output logic             carry_out
);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         q <= '0;
      end else if (inc) begin
         q <= (q == BCD_MAX) ? '0 : q + BCD_W'(1);
      end
   end

   assign carry_out = inc && (q == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button sync/edge detect, 100 Hz prescaler, IDLE/RUN/PAUSE/DONE FSM,
// cascaded BCD count. Optional lap display hold is enabled by defining LAP_HOLD_EN.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned TICK_DIV    = TICK_DIV_DEFAULT,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_start_stop,
   input  logic             btn_clear,
   input  logic             btn_lap,
   output logic [BCD_W-1:0] digit3,
   output logic [BCD_W-1:0] digit2,
   output logic [BCD_W-1:0] digit1,
   output logic [BCD_W-1:0] digit0,
   output logic             running,
   output logic             overflow
);

   localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

   logic [NUM_BTN-1:0] w_btn;
   logic [NUM_BTN-1:0] w_evt;
   logic               w_ss_evt;
   logic               w_clr_evt;

   state_t             r_state;
   logic               r_running;
   logic               r_overflow;
   logic [PRESC_W-1:0] r_presc;
   logic               w_tick;
   logic               w_inc;
   logic               w_all_max;

   logic [NUM_DIGITS-1:0][BCD_W-1:0] w_q;
   logic [NUM_DIGITS-1:0]            w_dig_inc;
   logic [NUM_DIGITS-1:0]            w_dig_carry;
   logic                             w_unused_top_carry;
   bcd_time_t                        w_live;
   bcd_time_t                        w_disp;

   assign w_btn = {btn_lap, btn_clear, btn_start_stop};

   // Per-button synchronizer chain followed by a rising-edge detector
   for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
      logic [SYNC_STAGES-1:0] r_sync;
      logic                   r_edge;

      always_ff @(posedge clk) begin
         if (reset) begin
            r_sync <= '0;
            r_edge <= 1'b0;
         end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_btn[b]};
            r_edge <= r_sync[SYNC_STAGES-1];
         end
      end

      assign w_evt[b] = r_sync[SYNC_STAGES-1] & ~r_edge;
   end

   assign w_ss_evt  = w_evt[BTN_START_STOP];
   assign w_clr_evt = w_evt[BTN_CLEAR];

   // Prescaler only advances in RUN; holding it in PAUSE keeps the fractional hundredth
   always_ff @(posedge clk) begin
      if (reset || w_clr_evt || (r_state == ST_IDLE)) begin
         r_presc <= '0;
      end else if (r_state == ST_RUN) begin
         r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
      end
   end

   assign w_tick = (r_state == ST_RUN) && (r_presc == PRESC_LAST);

   assign w_live    = bcd_time_t'(w_q);
   assign w_all_max = time_is_max(w_live);
   assign w_inc     = w_tick && !w_all_max;

   assign w_dig_inc = {w_dig_carry[NUM_DIGITS-2:0], w_inc};
   assign w_unused_top_carry = w_dig_carry[NUM_DIGITS-1];

   for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
      bcd_digit_counter u_digit (
         .clk       (clk),
         .reset     (reset),
         .clr       (w_clr_evt),
         .inc       (w_dig_inc[d]),
         .q         (w_q[d]),
         .carry_out (w_dig_carry[d])
      );
   end

   // Control FSM; flag registers update together with the state
   always_ff @(posedge clk) begin
      if (reset || w_clr_evt) begin
         r_state    <= ST_IDLE;
         r_running  <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_ss_evt) begin
                  r_state   <= ST_RUN;
                  r_running <= 1'b1;
               end
            end
            ST_RUN: begin
               if (w_tick && w_all_max) begin
                  r_state    <= ST_DONE;
                  r_running  <= 1'b0;
                  r_overflow <= 1'b1;
               end else if (w_ss_evt) begin
                  r_state   <= ST_PAUSE;
                  r_running <= 1'b0;
               end
            end
            ST_PAUSE: begin
               if (w_ss_evt) begin
                  r_state   <= ST_RUN;
                  r_running <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_DONE;
            end
            default: begin
               r_state    <= ST_IDLE;
               r_running  <= 1'b0;
               r_overflow <= 1'b0;
            end
         endcase
      end
   end

`ifdef LAP_HOLD_EN
   bcd_time_t r_hold_time;
   logic      r_hold;

   // Lap toggles a frozen copy of the count on the display; counting continues underneath
   always_ff @(posedge clk) begin
      if (reset || w_clr_evt) begin
         r_hold      <= 1'b0;
         r_hold_time <= '0;
      end else if (w_evt[BTN_LAP] && (r_state == ST_RUN)) begin
         if (r_hold) begin
            r_hold <= 1'b0;
         end else begin
            r_hold      <= 1'b1;
            r_hold_time <= w_live;
         end
      end
   end

   assign w_disp = r_hold ? r_hold_time : w_live;
`else
   logic w_unused_lap;

   assign w_unused_lap = w_evt[BTN_LAP];
   assign w_disp       = w_live;
`endif

   assign digit3   = w_disp.d3;
   assign digit2   = w_disp.d2;
   assign digit1   = w_disp.d1;
   assign digit0   = w_disp.d0;
   assign running  = r_running;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with TICK_DIV = 4; expectations are queued by the
// stimulus thread and compared by a negedge monitor.
module tb_stopwatch_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_start_stop;
   logic       btn_clear;
   logic       btn_lap;
   logic [3:0] digit3;
   logic [3:0] digit2;
   logic [3:0] digit1;
   logic [3:0] digit0;
   logic       running;
   logic       overflow;

   typedef struct {
      string       name;
      logic [15:0] digits;
      logic        running;
      logic        overflow;
   } exp_t;

   exp_t q_exp[$];
   int   n_checks = 0;
   int   n_errors = 0;

   stopwatch_ctrl #(
      .TICK_DIV    (4),
      .SYNC_STAGES (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .btn_start_stop (btn_start_stop),
      .btn_clear      (btn_clear),
      .btn_lap        (btn_lap),
      .digit3         (digit3),
      .digit2         (digit2),
      .digit1         (digit1),
      .digit0         (digit0),
      .running        (running),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_st(input string name, input logic [15:0] d,
                            input logic run, input logic ovf);
      exp_t e;
      e.name     = name;
      e.digits   = d;
      e.running  = run;
      e.overflow = ovf;
      q_exp.push_back(e);
   endtask

   always @(negedge clk) begin : monitor
      exp_t        e;
      logic [15:0] got;
      got = {digit3, digit2, digit1, digit0};
      while (q_exp.size() > 0) begin
         e = q_exp.pop_front();
         n_checks++;
         if (got !== e.digits || running !== e.running || overflow !== e.overflow) begin
            n_errors++;
            $display("FAIL %s: got digits=%h running=%b overflow=%b, expected digits=%h running=%b overflow=%b",
                     e.name, got, running, overflow, e.digits, e.running, e.overflow);
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      n_errors++;
      $display("FAIL watchdog: got simulation still running at time limit, expected completion");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin : stimulus
      reset          = 1'b1;
      btn_start_stop = 1'b0;
      btn_clear      = 1'b0;
      btn_lap        = 1'b0;
      cyc(3);
      expect_st("reset", 16'h0000, 1'b0, 1'b0);
      reset = 1'b0;
      cyc(100);
      expect_st("idle_100", 16'h0000, 1'b0, 1'b0);

      // start: acted on 3 cycles after press, first increment 4 cycles later
      btn_start_stop = 1'b1;
      cyc(2);
      expect_st("start_lat_2", 16'h0000, 1'b0, 1'b0);
      cyc(1);
      expect_st("start_lat_3", 16'h0000, 1'b1, 1'b0);
      btn_start_stop = 1'b0;
      cyc(3);
      expect_st("pre_first_tick", 16'h0000, 1'b1, 1'b0);
      cyc(1);
      expect_st("first_tick", 16'h0001, 1'b1, 1'b0);
      cyc(36);
      expect_st("ten_ticks", 16'h0010, 1'b1, 1'b0);

      // pause with prescaler at 3, hold, resume -> tick in the first RUN cycle
      btn_start_stop = 1'b1;
      cyc(3);
      expect_st("paused", 16'h0010, 1'b0, 1'b0);
      btn_start_stop = 1'b0;
      cyc(50);
      expect_st("pause_hold_mid", 16'h0010, 1'b0, 1'b0);
      cyc(50);
      expect_st("pause_hold_end", 16'h0010, 1'b0, 1'b0);
      btn_start_stop = 1'b1;
      cyc(3);
      expect_st("resumed", 16'h0010, 1'b1, 1'b0);
      btn_start_stop = 1'b0;
      cyc(1);
      expect_st("resume_tick", 16'h0011, 1'b1, 1'b0);

      // clear and start_stop together while running: clear wins
      cyc(4);
      btn_start_stop = 1'b1;
      btn_clear      = 1'b1;
      cyc(2);
      expect_st("clr_ss_lat_2", 16'h0012, 1'b1, 1'b0);
      cyc(1);
      expect_st("clr_ss_idle", 16'h0000, 1'b0, 1'b0);
      btn_start_stop = 1'b0;
      btn_clear      = 1'b0;
      cyc(6);
      expect_st("clr_ss_stays_idle", 16'h0000, 1'b0, 1'b0);

      // long run: full carry chain at 09.99 and saturation at 99.99
      btn_start_stop = 1'b1;
      cyc(3);
      expect_st("run2_start", 16'h0000, 1'b1, 1'b0);
      btn_start_stop = 1'b0;
      cyc(3995);
      expect_st("count_0998", 16'h0998, 1'b1, 1'b0);
      cyc(1);
      expect_st("count_0999", 16'h0999, 1'b1, 1'b0);
      cyc(3);
      expect_st("pre_carry", 16'h0999, 1'b1, 1'b0);
      cyc(1);
      expect_st("carry_chain", 16'h1000, 1'b1, 1'b0);
      cyc(35999);
      expect_st("at_max", 16'h9999, 1'b1, 1'b0);
      cyc(1);
      expect_st("done", 16'h9999, 1'b0, 1'b1);
      btn_start_stop = 1'b1;
      cyc(5);
      expect_st("done_ignores_ss", 16'h9999, 1'b0, 1'b1);
      btn_start_stop = 1'b0;
      cyc(20);
      expect_st("done_hold", 16'h9999, 1'b0, 1'b1);
      btn_clear = 1'b1;
      cyc(2);
      expect_st("done_clr_lat", 16'h9999, 1'b0, 1'b1);
      cyc(1);
      expect_st("done_cleared", 16'h0000, 1'b0, 1'b0);
      btn_clear = 1'b0;
      cyc(3);

      // reset while running
      btn_start_stop = 1'b1;
      cyc(3);
      btn_start_stop = 1'b0;
      cyc(20);
      expect_st("run3_count", 16'h0005, 1'b1, 1'b0);
      reset = 1'b1;
      cyc(1);
      expect_st("midrun_reset", 16'h0000, 1'b0, 1'b0);
      reset = 1'b0;
      cyc(4);
      expect_st("post_reset_idle", 16'h0000, 1'b0, 1'b0);

      // reset discards a press still in the synchronizer
      btn_start_stop = 1'b1;
      cyc(1);
      reset          = 1'b1;
      btn_start_stop = 1'b0;
      cyc(1);
      reset = 1'b0;
      expect_st("inflight_reset", 16'h0000, 1'b0, 1'b0);
      cyc(6);
      expect_st("inflight_discarded", 16'h0000, 1'b0, 1'b0);

      // lap at 00.05, internal count reaches 00.20, second lap shows live 00.21
      btn_start_stop = 1'b1;
      cyc(3);
      btn_start_stop = 1'b0;
      cyc(19);
      btn_lap = 1'b1;
      cyc(3);
      btn_lap = 1'b0;
      expect_st("lap_capture", 16'h0005, 1'b1, 1'b0);
      cyc(58);
`ifdef LAP_HOLD_EN
      expect_st("lap_frozen", 16'h0005, 1'b1, 1'b0);
`else
      expect_st("lap_ignored", 16'h0020, 1'b1, 1'b0);
`endif
      cyc(1);
      btn_lap = 1'b1;
      cyc(3);
      btn_lap = 1'b0;
      expect_st("lap_release", 16'h0021, 1'b1, 1'b0);

      btn_clear = 1'b1;
      cyc(3);
      btn_clear = 1'b0;
      expect_st("final_clear", 16'h0000, 1'b0, 1'b0);
      cyc(2);

      if (q_exp.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", q_exp.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Stopwatch sequencer that generates the four BCD digits consumed by the board's 4-digit seven-segment driver, in SS.hh format: seconds 00-99 and hundredths 00-99. The decimal point is fixed on digit2. It converts debounced start/stop and clear button levels into edge events and runs an IDLE/RUN/PAUSE/DONE state machine. A prescaled 100 Hz tick advances a cascaded BCD count. It sits between the board buttons and the display driver.

Parameters:
TICK_DIV, 1_000_000, clk cycles per hundredth-second tick (100 MHz clk -> 100 Hz); must be >= 2
SYNC_STAGES, 2, synchronizer flops per button input; minimum 2

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high; clears all state
btn_start_stop  input  1  debounced, asynchronous button level
btn_clear  input  1  debounced, asynchronous button level
btn_lap  input  1  debounced button level; used only with LAP_HOLD_EN, otherwise ignored
digit3  output  4  BCD tens of seconds
digit2  output  4  BCD units of seconds
digit1  output  4  BCD tens of hundredths
digit0  output  4  BCD units of hundredths
running  output  1  high while state == RUN
overflow  output  1  high while state == DONE

Behaviour:
- Reset values: state IDLE; digit3..0 = 0; running = 0; overflow = 0; prescaler = 0; all synchronizer and edge flops = 0.
- Button path: each button passes through SYNC_STAGES flops, then one edge flop. An event is a one-cycle pulse on a 0->1 of the synchronized level. A rising input edge is acted on, and state/outputs update, SYNC_STAGES+1 cycles later (3 at default). Holding a button produces exactly one event.
- Prescaler: counts 0..TICK_DIV-1 only in RUN. tick is asserted in the cycle it equals TICK_DIV-1, and it wraps to 0. It holds its value in PAUSE, so fractional time is preserved. It is forced to 0 on reset, on a clear event, and in IDLE.
- Count: four cascaded mod-10 BCD digits. digit0 increments on tick; each digit carries into the next when it is 9 and its carry-in is high. Valid range is 00.00..99.99. No digit ever holds a value above 9.
- State transitions (on events only, otherwise hold):
  IDLE  + start_stop -> RUN
  RUN   + start_stop -> PAUSE
  PAUSE + start_stop -> RUN
  RUN   + tick while count == 99.99 -> DONE; count stays 99.99 and does not wrap
  DONE  + start_stop -> DONE (ignored)
  any   + clear -> IDLE; count = 00.00; prescaler = 0
- Simultaneous events: clear has priority over start_stop and lap. If a tick and a start_stop (RUN->PAUSE) occur in the same cycle, the tick is applied first, so the count advances and then the block pauses.
- Outputs are registered. running and overflow decode the registered state with no extra latency relative to the state.
- Reset asserted mid-operation: the next cycle equals post-reset state. Events in flight are discarded.

Optional Feature:
Macro LAP_HOLD_EN.
- Defined: adds a 16-bit display hold register and a hold flag.
  - A lap event in RUN with hold=0 copies the count into the hold register and sets hold=1. digit3..0 then show the hold register while counting continues.
  - A lap event with hold=1 clears hold, and the display returns to the live count.
  - A lap event in IDLE, PAUSE or DONE is ignored.
  - clear or reset clears hold.
- Not defined: btn_lap is unused; digit3..0 always show the live count.

Decomposition:
- Package stopwatch_pkg:
  - state enum: IDLE, RUN, PAUSE, DONE (2 bits)
  - BCD_MAX = 4'd9
  - default TICK_DIV constant
- Sub-module bcd_digit_counter: one mod-10 digit.
  - Inputs: clk, reset, clr, inc.
  - Outputs: q[3:0], carry_out = inc && q == 9.
  - Instantiated 4 times.
- Button synchronizer and edge detector: inline generate loop.

Test Plan:
Run all scenarios with TICK_DIV = 4.
- Reset then idle 100 cycles -> digits 0,0,0,0; running = 0; overflow = 0.
- start_stop pulse, then 10 ticks (40 cycles) -> digits 0,0,1,0; running = 1. First increment occurs 3 + 4 cycles after the press.
- Preload 09.99 via run, then one tick -> 1,0,0,0, exercising the full carry chain. At 99.99 plus one tick -> state DONE, digits 9,9,9,9, overflow = 1. A further start_stop press is ignored.
- Pause after 3 cycles into a tick period, wait 100 cycles, resume -> the next increment comes 1 cycle after the resume takes effect (the prescaler was held), and the count was unchanged during the pause.
- clear and start_stop rising in the same cycle while in RUN -> IDLE, 00.00, running = 0.
- LAP_HOLD_EN: lap at 00.05 -> display frozen at 00.05 while the internal count reaches 00.20. Second lap -> display shows 00.20 or later.
